// File: rtl/switch_sequencer.sv
// Sequences the photonic switch bank through a programmed (pattern, dwell) table,
// pacing each entry with an external down-counter that it loads and watches.
module switch_sequencer #(
   parameter int WIDTH = 16,
   parameter int CH    = 4,
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cfg_we,
   input  logic [AW-1:0]    cfg_addr,
   input  logic [CH-1:0]    cfg_pattern,
   input  logic [WIDTH-1:0] cfg_dwell,
   input  logic [AW-1:0]    num_steps,
   input  logic             loop,
   input  logic             start,
   input  logic             abort,
   input  logic [WIDTH-1:0] cnt_q,
   output logic             cnt_load,
   output logic             cnt_en,
   output logic [WIDTH-1:0] cnt_limit,
   output logic [CH-1:0]    sw_out,
   output logic [AW-1:0]    step_idx,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [CH-1:0]    pat_q [DEPTH];
   logic [CH-1:0]    pat_d [DEPTH];
   logic [WIDTH-1:0] dwell_q [DEPTH];
   logic [WIDTH-1:0] dwell_d [DEPTH];
   logic [CH-1:0]    sw_q, sw_d;
   logic [AW-1:0]    idx_q, idx_d;
   logic [AW-1:0]    nxt_idx;

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         pat_d[i]   = pat_q[i];
         dwell_d[i] = dwell_q[i];
      end
      if (cfg_we) begin
         pat_d[cfg_addr]   = cfg_pattern;
         dwell_d[cfg_addr] = cfg_dwell;
      end
   end

   always_comb begin
      nxt_idx = (idx_q == num_steps) ? '0 : idx_q + AW'(1);
      state_d = state_q;
      sw_d    = sw_q;
      idx_d   = idx_q;
      case (state_q)
         S_IDLE: begin
            sw_d = '0;
            if (start && !abort) begin
               idx_d   = '0;
               sw_d    = pat_q[0];
               state_d = S_LOAD;
            end
         end
         S_LOAD: state_d = S_RUN;
         S_RUN: begin
            // Pattern is latched on the edge into LOAD, so table writes to the
            // running entry only show up on that entry's next pass.
            if (cnt_q == '0) begin
               if (idx_q != num_steps || loop) begin
                  idx_d   = nxt_idx;
                  sw_d    = pat_q[nxt_idx];
                  state_d = S_LOAD;
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            sw_d    = '0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (abort && state_q != S_IDLE) begin
         state_d = S_IDLE;
         sw_d    = '0;
         idx_d   = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         sw_q    <= '0;
         idx_q   <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            pat_q[i]   <= '0;
            dwell_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         sw_q    <= sw_d;
         idx_q   <= idx_d;
         for (int i = 0; i < DEPTH; i++) begin
            pat_q[i]   <= pat_d[i];
            dwell_q[i] <= dwell_d[i];
         end
      end
   end

   assign cnt_load  = (state_q == S_LOAD);
   assign cnt_en    = (state_q == S_LOAD) || (state_q == S_RUN);
   assign busy      = cnt_en;
   assign done      = (state_q == S_DONE);
   assign cnt_limit = dwell_q[idx_q];
   assign sw_out    = sw_q;
   assign step_idx  = idx_q;

endmodule

// File: tb/tb_switch_sequencer.sv
// Bench for switch_sequencer: a behavioural down-counter plus a timeline model
// that expands the entry table into expected per-cycle outputs.
module tb_switch_sequencer;
   localparam int W = 16, CH = 4, D = 8, AW = 3;

   logic          clk = 0, reset = 1;
   logic          cfg_we = 0, loop = 0, start = 0, abort = 0;
   logic [AW-1:0] cfg_addr = '0, num_steps = '0;
   logic [CH-1:0] cfg_pattern = '0;
   logic [W-1:0]  cfg_dwell = '0, cnt_q;
   logic          cnt_load, cnt_en, busy, done;
   logic [W-1:0]  cnt_limit;
   logic [CH-1:0] sw_out;
   logic [AW-1:0] step_idx;

   int checks = 0, errors = 0;
   int mpat [D];
   int mdw  [D];

   switch_sequencer #(.WIDTH(W), .CH(CH), .DEPTH(D), .AW(AW)) dut (
      .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
      .cfg_pattern(cfg_pattern), .cfg_dwell(cfg_dwell), .num_steps(num_steps),
      .loop(loop), .start(start), .abort(abort), .cnt_q(cnt_q),
      .cnt_load(cnt_load), .cnt_en(cnt_en), .cnt_limit(cnt_limit),
      .sw_out(sw_out), .step_idx(step_idx), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                    cnt_q <= '0;
      else if (cnt_load)            cnt_q <= cnt_limit;
      else if (cnt_en && cnt_q != 0) cnt_q <= cnt_q - 1'b1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic write_entry(input int a, input int p, input int d);
      cfg_we = 1; cfg_addr = AW'(a); cfg_pattern = CH'(p); cfg_dwell = W'(d);
      @(posedge clk); #1;
      cfg_we = 0;
      mpat[a] = p; mdw[a] = d;
   endtask

   // Expected timeline: idle cycle 0 (start sampled), then each step is
   // d+2 cycles of its pattern; a non-looping end shows one done cycle.
   task automatic run_seq(input int ns, input bit lp, input int ncyc, input int abort_at,
                          input int restart_at, input int wr_cyc, input int wr_idx,
                          input int wr_pat, input int wr_dw);
      int e_sw[$], e_busy[$], e_done[$], e_idx[$], e_load[$], e_lim[$];
      int i = 0;
      bit ended = 0;
      e_sw.push_back(0); e_busy.push_back(0); e_done.push_back(0);
      e_idx.push_back(-1); e_load.push_back(0); e_lim.push_back(-1);
      while (e_sw.size() < ncyc && !ended) begin
         int L = e_sw.size();
         bit nw = (wr_cyc >= 0 && wr_idx == i && wr_cyc < L - 1);
         int p = nw ? wr_pat : mpat[i];
         int d = nw ? wr_dw : mdw[i];
         for (int k = 0; k < d + 2; k++) begin
            e_sw.push_back(p); e_busy.push_back(1); e_done.push_back(0);
            e_idx.push_back(i); e_load.push_back(k == 0 ? 1 : 0); e_lim.push_back(k == 0 ? d : -1);
         end
         if (i == ns) begin
            if (!lp) begin
               e_sw.push_back(p); e_busy.push_back(0); e_done.push_back(1);
               e_idx.push_back(ns); e_load.push_back(0); e_lim.push_back(-1);
               ended = 1;
            end
            i = 0;
         end else i++;
      end
      while (e_sw.size() < ncyc) begin
         e_sw.push_back(0); e_busy.push_back(0); e_done.push_back(0);
         e_idx.push_back(ns); e_load.push_back(0); e_lim.push_back(-1);
      end
      if (abort_at >= 0)
         for (int c = abort_at + 1; c < ncyc; c++) begin
            e_sw[c] = 0; e_busy[c] = 0; e_done[c] = 0; e_idx[c] = 0; e_load[c] = 0; e_lim[c] = -1;
         end
      num_steps = AW'(ns); loop = lp;
      for (int c = 0; c < ncyc; c++) begin
         start = (c == 0 || c == restart_at);
         abort = (c == abort_at);
         cfg_we = (c == wr_cyc);
         cfg_addr = AW'(wr_idx); cfg_pattern = CH'(wr_pat); cfg_dwell = W'(wr_dw);
         @(negedge clk);
         chk($sformatf("sw_out@%0d", c), 32'(sw_out), e_sw[c]);
         chk($sformatf("busy@%0d", c), 32'(busy), e_busy[c]);
         chk($sformatf("cnt_en@%0d", c), 32'(cnt_en), e_busy[c]);
         chk($sformatf("done@%0d", c), 32'(done), e_done[c]);
         chk($sformatf("cnt_load@%0d", c), 32'(cnt_load), e_load[c]);
         if (e_idx[c] >= 0) chk($sformatf("step_idx@%0d", c), 32'(step_idx), e_idx[c]);
         if (e_lim[c] >= 0) chk($sformatf("cnt_limit@%0d", c), 32'(cnt_limit), e_lim[c]);
         @(posedge clk); #1;
      end
      start = 0; abort = 0; cfg_we = 0;
      if (wr_cyc >= 0) begin mpat[wr_idx] = wr_pat; mdw[wr_idx] = wr_dw; end
   endtask

   initial begin
      for (int a = 0; a < D; a++) begin mpat[a] = 0; mdw[a] = 0; end
      #1;
      chk("rst_sw_out", 32'(sw_out), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_step_idx", 32'(step_idx), 0);
      chk("rst_cnt_load", 32'(cnt_load), 0);
      chk("rst_cnt_en", 32'(cnt_en), 0);
      #13 reset = 0;
      @(posedge clk); #1;

      write_entry(0, 'h1, 3);
      write_entry(1, 'h2, 0);
      write_entry(2, 'h4, 5);
      run_seq(2, 0, 20, -1, -1, -1, 0, 0, 0);
      run_seq(2, 0, 20, -1, 3, -1, 0, 0, 0);
      run_seq(2, 1, 24, 20, -1, -1, 0, 0, 0);
      run_seq(2, 1, 34, 30, -1, 7, 1, 'h8, 2);

      start = 1; abort = 1;
      @(posedge clk); #1;
      start = 0; abort = 0;
      chk("start_abort_busy", 32'(busy), 0);
      chk("start_abort_sw", 32'(sw_out), 0);

      num_steps = 2; loop = 0; start = 1;
      @(posedge clk); #1;
      start = 0;
      repeat (3) @(posedge clk);
      #3 reset = 1;
      #1;
      chk("async_rst_sw", 32'(sw_out), 0);
      chk("async_rst_busy", 32'(busy), 0);
      chk("async_rst_cnt_en", 32'(cnt_en), 0);
      #2 reset = 0;
      for (int a = 0; a < D; a++) begin mpat[a] = 0; mdw[a] = 0; end
      @(posedge clk); #1;
      run_seq(7, 0, 22, -1, -1, -1, 0, 0, 0);

      for (int it = 0; it < 6; it++) begin
         int ns = $urandom_range(0, D - 1);
         bit lp = 1'($urandom_range(0, 1));
         int tot = 0;
         for (int a = 0; a < D; a++) begin
            write_entry(a, $urandom_range(0, 15), $urandom_range(0, 5));
            if (a <= ns) tot += mdw[a] + 2;
         end
         if (lp) begin
            int ab = $urandom_range(1, 40);
            run_seq(ns, 1, ab + 4, ab, -1, -1, 0, 0, 0);
         end else begin
            run_seq(ns, 0, tot + 4, -1, -1, -1, 0, 0, 0);
         end
      end

      write_entry(0, 'hF, 'hFFFF);
      run_seq(0, 0, 65537 + 4, -1, -1, -1, 0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/switch_sequencer.md
Name: switch_sequencer

Overview:
Steps the photonic switch bank through a programmed list of (pattern, dwell) entries. It drives an external down-counter of matching WIDTH through that counter's load/en/limit inputs and watches its Q output. Each dwell is loaded into the counter, the entry's pattern is held on the switch lines, and the sequencer advances when Q reaches 0. It sits between the configuration/decoder logic and the switch drivers.

Parameters:
WIDTH, 16, dwell/counter width in bits (must match the counter instance)
CH, 4, number of switch channels (pattern width)
DEPTH, 8, number of sequence entries
AW, 3, entry index width, clog2(DEPTH)

Ports:
clk  in  1  system clock, all state updates on posedge
reset  in  1  asynchronous, active-high; clears all state
cfg_we  in  1  write strobe for the entry table
cfg_addr  in  AW  entry index to write
cfg_pattern  in  CH  switch pattern for the entry
cfg_dwell  in  WIDTH  dwell value for the entry
num_steps  in  AW  index of the last entry used (sequence length = num_steps+1)
loop  in  1  1 = wrap from the last entry back to entry 0 and continue
start  in  1  begin a sequence (level-sampled, honoured only in IDLE)
abort  in  1  stop immediately, return to IDLE
cnt_q  in  WIDTH  counter Q output
cnt_load  out  1  counter load
cnt_en  out  1  counter enable
cnt_limit  out  WIDTH  value loaded into the counter
sw_out  out  CH  registered switch pattern to the drivers
step_idx  out  AW  current entry index
busy  out  1  high in LOAD or RUN
done  out  1  one-cycle pulse at normal sequence end

Behaviour:
- Reset (async): state=IDLE; sw_out=0; step_idx=0; done=0; all table entries set to pattern 0, dwell 0. cnt_load, cnt_en and busy are 0 because they decode from state.
- Table write: the entry at cfg_addr takes cfg_pattern/cfg_dwell at the clk edge when cfg_we=1. Writes are allowed in any state. A write to the active entry does not change sw_out or the running count; it takes effect at that entry's next LOAD.
- FSM states: IDLE, LOAD, RUN, DONE. Outputs are Moore-decoded from state.
- IDLE: cnt_en=0, cnt_load=0, sw_out=0. If start=1 and abort=0: step_idx<=0, go to LOAD.
- LOAD (1 cycle): cnt_load=1, cnt_en=1, cnt_limit=dwell[step_idx]. sw_out<=pattern[step_idx] on entry to LOAD, so it is visible during the LOAD cycle. Next state is RUN.
- RUN: cnt_en=1, cnt_load=0. cnt_q shows d, d-1, …, 0 on successive cycles. When cnt_q==0:
  - if step_idx!=num_steps: step_idx+1, go to LOAD;
  - else if loop=1: step_idx<=0, go to LOAD;
  - else go to DONE.
- Step duration = d+2 cycles (1 LOAD + d+1 RUN). dwell 0 gives 2 cycles. Max dwell 2^WIDTH-1 has no overflow.
- DONE (1 cycle): done=1, sw_out<=0, next state is IDLE.
- cnt_limit is driven with dwell[step_idx] in every state. Only LOAD is significant.
- abort=1 in LOAD, RUN or DONE: next state is IDLE, sw_out<=0, step_idx<=0, no done pulse. abort beats start in the same cycle.
- start while busy is ignored. num_steps greater than DEPTH-1 cannot be represented, since AW bits are used.
- Changing num_steps or loop mid-sequence is sampled at each RUN completion.

Test Plan:
- 3 entries (0x1,3), (0x2,0), (0x4,5); num_steps=2; loop=0; pulse start in cycle 0, with a real down-counter instance -> sw_out=0x1 in cycles 1–5, 0x2 in 6–7, 0x4 in 8–14; done pulse in cycle 15; sw_out=0 and busy=0 from cycle 16.
- Same table with loop=1 -> sw_out returns to 0x1 in cycle 15 with no done; abort asserted in cycle 20 -> IDLE in cycle 21, sw_out=0, no done ever.
- Assert reset mid-RUN (not clock-aligned) -> sw_out, busy, cnt_en go to 0 immediately; reading the table back via a sequence afterwards shows all patterns 0.
- start re-pulsed during RUN -> ignored, timing identical to the first scenario; start and abort together in IDLE -> stays IDLE, busy=0.
- num_steps=0, dwell=0xFFFF, pattern 0xF -> sw_out=0xF for exactly 65537 cycles, then a single done pulse.
- During RUN of entry 1, write entry 1 = (0x8,2) -> sw_out stays at the old value until the next loop pass, which shows 0x8 for 4 cycles.
